// File: rtl/sd_clk_drp_ctrl.sv
// ============================================================================
// Module   : sd_clk_drp_ctrl
// Brief    : DRP read-modify-write controller that retunes CLKOUT0 of the SD
//            clock MMCM, cycles its reset and waits for lock.
//            Optional macro SD_CLK_DRP_READBACK_EN adds post-write readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_clk_drp_ctrl #(
  parameter logic [6:0] REG1_ADDR = 7'h08,
  parameter logic [6:0] REG2_ADDR = 7'h09,
  parameter int         DRDY_TMO  = 1024,
  parameter int         LOCK_TMO  = 65536
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_div,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_din,
  input  logic [15:0] drp_dout,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  localparam int CNT_W = $clog2((LOCK_TMO > DRDY_TMO) ? LOCK_TMO : DRDY_TMO) + 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST_ON    = 4'd1,
    S_RD        = 4'd2,
    S_RD_WAIT   = 4'd3,
    S_WR        = 4'd4,
    S_WR_WAIT   = 4'd5,
    S_NEXT      = 4'd6,
    S_REL       = 4'd7,
    S_LOCK_WAIT = 4'd8,
    S_DONE      = 4'd9
`ifdef SD_CLK_DRP_READBACK_EN
    ,
    S_RB        = 4'd10,
    S_RB_WAIT   = 4'd11
`endif
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       div_q;
  logic             sel, sel_nx;
  logic [CNT_W-1:0] cnt;
  logic             legal, set_err, rd_go, wr_go;
  logic             tmo_drdy, tmo_lock;
  logic [5:0]       hi, lo;
  logic             edge_bit, nocnt;
  logic [15:0]      wr_val;
`ifdef SD_CLK_DRP_READBACK_EN
  logic [15:0]      wr1_q;
  logic             rb_mismatch;
`endif

  assign legal    = (req_div != 8'd0) && (req_div <= 8'd128);
  assign tmo_drdy = (cnt >= CNT_W'(DRDY_TMO - 1));
  assign tmo_lock = (cnt >= CNT_W'(LOCK_TMO - 1));

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Divide-by-1 uses bypass (no_count) with an even 1/1 split, so edge stays 0.
  always_comb begin
    if (div_q == 8'd1) begin
      hi       = 6'd1;
      lo       = 6'd1;
      edge_bit = 1'b0;
      nocnt    = 1'b1;
    end else begin
      hi       = div_q[6:1];
      lo       = 6'(div_q - {1'b0, div_q[7:1]});
      edge_bit = div_q[0];
      nocnt    = 1'b0;
    end
    if (!sel) wr_val = (drp_dout & 16'hF000) | {4'h0, hi, lo};
    else      wr_val = (drp_dout & 16'hFF3F) | {8'h00, edge_bit, nocnt, 6'b0};
  end

`ifdef SD_CLK_DRP_READBACK_EN
  assign rb_mismatch = (drp_dout != (sel ? drp_din : wr1_q));
`endif

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    set_err  = 1'b0;
    case (state)
      S_IDLE:      if (req_valid) begin
                     state_nx = legal ? S_RST_ON : S_DONE;
                     sel_nx   = 1'b0;
                   end
      S_RST_ON:    state_nx = S_RD;
      S_RD:        state_nx = S_RD_WAIT;
      S_RD_WAIT:   if (drp_drdy) state_nx = S_WR;
                   else if (tmo_drdy) begin
                     state_nx = S_REL;
                     set_err  = 1'b1;
                   end
      S_WR:        state_nx = S_WR_WAIT;
      S_WR_WAIT:   if (drp_drdy) state_nx = S_NEXT;
                   else if (tmo_drdy) begin
                     state_nx = S_REL;
                     set_err  = 1'b1;
                   end
      S_NEXT:      if (!sel) begin
                     state_nx = S_RD;
                     sel_nx   = 1'b1;
                   end else begin
`ifdef SD_CLK_DRP_READBACK_EN
                     state_nx = S_RB;
                     sel_nx   = 1'b0;
`else
                     state_nx = S_REL;
`endif
                   end
`ifdef SD_CLK_DRP_READBACK_EN
      S_RB:        state_nx = S_RB_WAIT;
      S_RB_WAIT:   if (drp_drdy) begin
                     set_err = rb_mismatch;
                     if (!sel) begin
                       state_nx = S_RB;
                       sel_nx   = 1'b1;
                     end else begin
                       state_nx = S_REL;
                     end
                   end else if (tmo_drdy) begin
                     state_nx = S_REL;
                     set_err  = 1'b1;
                   end
`endif
      S_REL:       state_nx = S_LOCK_WAIT;
      S_LOCK_WAIT: if (mmcm_locked && !mmcm_rst) state_nx = S_DONE;
                   else if (tmo_lock) begin
                     state_nx = S_DONE;
                     set_err  = 1'b1;
                   end
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_go = (state_nx == S_RD);
`ifdef SD_CLK_DRP_READBACK_EN
    rd_go = rd_go || (state_nx == S_RB);
`endif
    wr_go = (state_nx == S_WR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      div_q     <= 8'd0;
      sel       <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
      mmcm_rst  <= 1'b0;
      drp_daddr <= 7'd0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_din   <= 16'd0;
`ifdef SD_CLK_DRP_READBACK_EN
      wr1_q     <= 16'd0;
`endif
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      cnt     <= (state_nx != state) ? '0 : cnt + CNT_W'(1);
      drp_den <= rd_go || wr_go;

      if (state == S_IDLE && req_valid) begin
        div_q <= req_div;
        err   <= !legal;
      end else if (set_err) begin
        err <= 1'b1;
      end

      if (state_nx == S_RST_ON)   mmcm_rst <= 1'b1;
      else if (state_nx == S_REL) mmcm_rst <= 1'b0;

      if (rd_go) begin
        drp_daddr <= sel_nx ? REG2_ADDR : REG1_ADDR;
        drp_dwe   <= 1'b0;
      end
      // The merged word is built straight from the returning read data.
      if (wr_go) begin
        drp_din <= wr_val;
        drp_dwe <= 1'b1;
`ifdef SD_CLK_DRP_READBACK_EN
        if (!sel) wr1_q <= wr_val;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_clk_drp_ctrl.sv
// ============================================================================
// Module   : tb_sd_clk_drp_ctrl
// Brief    : Scoreboard bench for sd_clk_drp_ctrl with DRP and MMCM models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_clk_drp_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_div = 8'd0;
  logic        busy, done, err;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_din;
  logic [15:0] drp_dout;
  logic        drp_drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;

  sd_clk_drp_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_div     (req_div),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .drp_daddr   (drp_daddr),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_din     (drp_din),
    .drp_dout    (drp_dout),
    .drp_drdy    (drp_drdy),
    .mmcm_rst    (mmcm_rst),
    .mmcm_locked (mmcm_locked)
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic e; logic legal; } dn_t;
  wr_t exp_wr[$];
  dn_t exp_dn[$];

  int n_pass = 0, n_total = 0;
  int cyc = 0, acc_cyc = 0;
  int den_cnt = 0, wr_cnt = 0, done_cnt = 0, rst_cyc = 0;
  logic withhold = 1'b0, corrupt = 1'b0, load = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // DRP slave: fixed 3-cycle read/write latency, tiny two-register memory.
  logic [1:0]  t;
  logic [6:0]  ra;
  logic [15:0] m8, m9;
  logic        w9;
  always @(posedge clk) begin
    if (!rstn) t <= 2'd0;
    else if (drp_den && !(withhold && drp_daddr == 7'h08)) begin
      t  <= 2'd3;
      ra <= drp_daddr;
    end else if (t != 2'd0) t <= t - 2'd1;
    if (load) begin
      m8 <= 16'hF1C3;
      m9 <= 16'hAB55;
      w9 <= 1'b0;
    end else if (rstn && drp_den && drp_dwe) begin
      if (drp_daddr == 7'h08) m8 <= drp_din;
      else if (drp_daddr == 7'h09) begin
        m9 <= drp_din;
        w9 <= 1'b1;
      end
    end
  end
  assign drp_drdy = (t == 2'd1);
  assign drp_dout = !drp_drdy ? 16'h0 : (ra == 7'h08) ? m8 : (corrupt && w9) ? 16'h0 : m9;

  // MMCM lock model: locks 20 cycles after reset release.
  int lc;
  always @(posedge clk) begin
    if (!rstn || mmcm_rst) begin
      lc <= 0;
      mmcm_locked <= 1'b0;
    end else if (lc < 19) lc <= lc + 1;
    else mmcm_locked <= 1'b1;
  end

  // Monitor: pops expectations whenever the DUT writes or signals done.
  always @(negedge clk) begin
    wr_t w;
    dn_t e;
    cyc <= cyc + 1;
    if (rstn && mmcm_rst) rst_cyc <= rst_cyc + 1;
    if (rstn && drp_den) begin
      den_cnt <= den_cnt + 1;
      if (drp_dwe) begin
        wr_cnt <= wr_cnt + 1;
        if (exp_wr.size() > 0) w = exp_wr.pop_front();
        else begin w.a = 7'h7f; w.d = 16'hxxxx; end
        check("wr_addr", {25'd0, drp_daddr}, {25'd0, w.a});
        check("wr_data", {16'd0, drp_din}, {16'd0, w.d});
        check("wr_rst_held", {31'd0, mmcm_rst}, 32'd1);
      end
    end
    if (rstn && done) begin
      done_cnt <= done_cnt + 1;
      if (exp_dn.size() > 0) e = exp_dn.pop_front();
      else begin e.e = 1'bx; e.legal = 1'b0; end
      check("done_err", {31'd0, err}, {31'd0, e.e});
      check("done_rst_low", {31'd0, mmcm_rst}, 32'd0);
      if (e.legal) check("done_latency_ge8", {31'd0, (cyc - acc_cyc) >= 8}, 32'd1);
    end
  end

  task automatic request(input logic [7:0] d);
    int g = 0;
    @(negedge clk);
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    req_valid = 1'b1;
    req_div   = d;
    load      = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    req_valid = 1'b0;
    load      = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int  start = done_cnt;
    logic seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
  endtask

  task automatic legal_req(input logic [7:0] d, input logic [15:0] r1, input logic [15:0] r2);
    exp_wr.push_back('{a: 7'h08, d: r1});
    exp_wr.push_back('{a: 7'h09, d: r2});
    exp_dn.push_back('{e: 1'b0, legal: 1'b1});
    request(d);
    wait_done(400);
  endtask

  task automatic reject_req(input logic [7:0] d);
    int dn0, rs0;
    dn0 = den_cnt;
    rs0 = rst_cyc;
    exp_dn.push_back('{e: 1'b1, legal: 1'b0});
    request(d);
    wait_done(50);
    check("reject_no_den", den_cnt, dn0);
    check("reject_no_rst", rst_cyc, rs0);
  endtask

  initial begin
    int d0, g;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_den", {31'd0, drp_den}, 32'd0);
    check("rst_daddr", {25'd0, drp_daddr}, 32'd0);
    check("rst_din", {16'd0, drp_din}, 32'd0);
    check("rst_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
    rstn = 1'b1;
    repeat (30) @(posedge clk);

    legal_req(8'd4,   16'hF082, 16'hAB15);
    legal_req(8'd5,   16'hF083, 16'hAB95);
    legal_req(8'd1,   16'hF041, 16'hAB55);
    legal_req(8'd128, 16'hF000, 16'hAB15);

    reject_req(8'd0);
    reject_req(8'd200);
    repeat (3) @(negedge clk);
    check("err_sticky_idle", {31'd0, err}, 32'd1);
    legal_req(8'd4, 16'hF082, 16'hAB15);

    withhold = 1'b1;
    exp_dn.push_back('{e: 1'b1, legal: 1'b1});
    request(8'd4);
    wait_done(3000);
    withhold = 1'b0;

`ifdef SD_CLK_DRP_READBACK_EN
    corrupt = 1'b1;
    exp_wr.push_back('{a: 7'h08, d: 16'hF082});
    exp_wr.push_back('{a: 7'h09, d: 16'hAB15});
    exp_dn.push_back('{e: 1'b1, legal: 1'b1});
    request(8'd4);
    wait_done(400);
    corrupt = 1'b0;
`endif

    // Abort in the middle of the REG1 write wait.
    exp_wr.push_back('{a: 7'h08, d: 16'hF082});
    d0 = wr_cnt;
    request(8'd4);
    g = 0;
    while (wr_cnt == d0 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("abort_write_seen", wr_cnt, d0 + 1);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
    check("abort_den", {31'd0, drp_den}, 32'd0);
    check("abort_dwe", {31'd0, drp_dwe}, 32'd0);
    check("abort_daddr", {25'd0, drp_daddr}, 32'd0);
    check("abort_din", {16'd0, drp_din}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt, d0);

    check("wr_queue_drained", exp_wr.size(), 0);
    check("done_queue_drained", exp_dn.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sd_clk_drp_ctrl.md
Name: sd_clk_drp_ctrl

Overview:
- DRP reconfiguration controller for the SD-card clock MMCM (`clk_wiz_1`). It sits directly upstream of that MMCM's DRP port and drives its daddr/den/din/dwe/reset pins.
- Accepts a requested integer output divider from the SD host logic. Programs CLKOUT0 by read-modify-write of two DRP registers, then cycles the MMCM reset and waits for lock.
- Reports done/error so SD software knows when `sd_sclk` is stable at the new frequency.

Parameters:
- REG1_ADDR, 7'h08, DRP address of CLKOUT0 ClkReg1 (phase mux, high time, low time).
- REG2_ADDR, 7'h09, DRP address of CLKOUT0 ClkReg2 (edge, no_count).
- DRDY_TMO, 1024, cycles to wait for drp_drdy before aborting.
- LOCK_TMO, 65536, cycles to wait for mmcm_locked after reset release before aborting.

Ports:
- clk  in  1  system clock (50 MHz CPU clock); also drives DRP dclk.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  divider change request.
- req_ready  out  1  high only in IDLE.
- req_div  in  8  requested CLKOUT0 divide value; legal range 1..128.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a request completes, successfully or not.
- err  out  1  sticky; set on reject or timeout; cleared on the next accepted request.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable; one-cycle pulse per access.
- drp_dwe  out  1  DRP write enable; qualified by drp_den.
- drp_din  out  16  DRP write data.
- drp_dout  in  16  DRP read data; valid with drp_drdy.
- drp_drdy  in  1  DRP access complete.
- mmcm_rst  out  1  MMCM reset; active high.
- mmcm_locked  in  1  MMCM lock indication.

Behaviour:
- Reset values (async, rstn=0):
  - All outputs 0, except req_ready=1.
  - FSM in IDLE; counters 0; err=0.
  - Asserting rstn mid-operation aborts immediately and drops mmcm_rst to 0. No completion pulse is generated.
- Handshake:
  - A request is accepted on req_valid & req_ready; req_div is latched.
  - The acceptance cycle clears err.
  - req_valid while busy is ignored, with no queueing.
- Divider encoding, from the latched value d:
  - high = d>>1, low = d-high, edge = d[0], nocnt = (d==1).
  - For d==1, high=low=1.
  - Field values of 64 are encoded as 6'd0 (6-bit truncation).
- Reject path: if d==0 or d>128, go IDLE->DONE. Set err, pulse done, no DRP traffic, mmcm_rst stays 0.
- States:
  - IDLE
  - RST_ON: mmcm_rst<=1.
  - RD: den pulse, dwe=0, daddr=current register.
  - RD_WAIT: wait drdy and capture dout.
  - WR: den pulse, dwe=1, din=merged value.
  - WR_WAIT: wait drdy.
  - NEXT: REG1 goes to RD for REG2; REG2 goes to REL.
  - REL: mmcm_rst<=0.
  - LOCK_WAIT
  - DONE: done=1 for one cycle, then IDLE.
- Read-modify-write merge rules:
  - REG1: din = (dout & 16'hF000) | high<<6 | low.
  - REG2: din = (dout & 16'hFF3F) | edge<<7 | nocnt<<6.
- DRP protocol:
  - drp_den is high for exactly one cycle per access.
  - daddr, dwe and din are held stable from the den cycle until drdy.
  - Only one access is outstanding at a time.
  - drdy arriving in the den cycle itself is not possible (the MMCM minimum latency is 1). drdy received outside a WAIT state is ignored.
- Timeouts:
  - The timeout counter resets on entry to each WAIT state.
  - RD_WAIT/WR_WAIT exceeding DRDY_TMO: set err, go REL. mmcm_rst is always released; lock is still awaited.
  - LOCK_WAIT exceeding LOCK_TMO: set err, go DONE.
- Lock handling:
  - mmcm_locked is ignored while mmcm_rst=1.
  - In LOCK_WAIT the first cycle with locked=1 goes to DONE.
- Latency: busy rises the cycle after acceptance. done asserts no earlier than 8 cycles after acceptance on the legal path.

Optional Feature:
- SD_CLK_DRP_READBACK_EN:
  - When defined, after the REG2 write the FSM performs a readback. It goes through RB (read REG1), RB_WAIT, RB (read REG2), RB_WAIT, then REL.
  - Each readback is compared against the value written. Any mismatch sets err; the flow still proceeds to REL and LOCK_WAIT.
  - When undefined, NEXT goes directly to REL, and the RB states and comparison logic are absent.

Test Plan:
- Even divider: req_div=4; bench returns dout 16'hF1C3 (REG1) and 16'hAB55 (REG2), drdy latency 3, locked after 20 cycles.
  -> writes 16'hF082 to 7'h08 and 16'hAB15 to 7'h09; mmcm_rst high across both writes; done pulse; err=0.
- Odd divider: req_div=5, same read data -> writes 16'hF083 and 16'hAB95.
- Bypass divider: req_div=1 -> writes 16'hF041 and 16'hAB55.
- Divider 128: req_div=128 -> REG1 written as 16'hF000.
- Reject: req_div=0, then req_div=200 -> no drp_den ever; err=1; one done pulse each; mmcm_rst=0 throughout.
- Timeout and abort:
  - drdy withheld on the REG1 read -> after 1024 cycles err=1, mmcm_rst drops, done follows lock.
  - Separately, rstn pulsed low mid-WR_WAIT -> all outputs return to reset values at once, req_ready=1.
- Readback mismatch (SD_CLK_DRP_READBACK_EN only): REG2 readback returns 16'h0000 -> err=1; done still pulses after lock.
